rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (we3/a3/wd3, written on falling clk edge) between the pipeline writeback stage and a long-latency multiply/divide unit.
- WB has priority and is never buffered.
- MD results queue in a small FIFO and drain to the port when it is free.
- A pending-destination scoreboard gives the hazard unit busy flags for registers awaiting MD writeback.
- Starvation of MD is bounded by a counter that stalls WB for one cycle.

Parameters:
DEPTH, 4, MD result FIFO entries; power of 2, >=2
STARVE_LIMIT, 3, consecutive cycles the FIFO head may be denied before WB is stalled; >=1

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
wb_we  in  1  WB write request
wb_rd  in  5  WB destination
wb_data  in  32  WB data
wb_stall  out  1  WB write refused this cycle; pipeline holds WB stage and re-presents
md_valid  in  1  MD result valid
md_ready  out  1  FIFO can accept
md_rd  in  5  MD destination
md_data  in  32  MD data
iss_valid  in  1  MD op issuing; marks iss_rd pending
iss_rd  in  5  destination of issuing MD op
iss_ready  out  1  issue accepted (iss_rd not already pending)
q1, q2, q3  in  5 each  hazard query addresses (rs1, rs2, rd)
busy1, busy2, busy3  out  1 each  queried register pending
rf_we  out  1  to regfile we3
rf_a3  out  5  to regfile a3
rf_wd3  out  32  to regfile wd3
err_waw  out  1  sticky: WB wrote a pending register

Behaviour:
Reset (reset_n=0 at posedge):
- FIFO emptied, pending mask cleared, starve counter cleared, err_waw cleared.
- While reset_n=0, rf_we=0, md_ready=0, iss_ready=0 and wb_stall=0 are forced combinationally.

Request qualification:
- WB request = wb_we && wb_rd!=0.
- MD enqueue = md_valid && md_ready. If md_rd==0 the result is consumed and discarded, not enqueued.
- md_ready = !full. It does not depend on a same-cycle dequeue.

Port grant (combinational, same cycle):
- starve = (cnt==STARVE_LIMIT) && !empty.
- If starve: grant FIFO head, wb_stall=WB request.
- Else if WB request: grant WB, wb_stall=0.
- Else if !empty: grant FIFO head.
- Else: rf_we=0.
- rf_a3/rf_wd3 follow the granted source. When rf_we=0 they are don't-care, driven as 0.

Starve counter:
- cnt increments when !empty and head not granted, saturating at STARVE_LIMIT.
- cnt clears when head granted or FIFO empty.

FIFO:
- Circular buffer with separate read/write pointers and count.
- Enqueue and dequeue in the same cycle are allowed at any non-full level; count is unchanged.
- Empty FIFO does not bypass: an enqueued entry is eligible the following cycle.

Scoreboard:
- 32-bit pending mask, bit 0 hard-wired 0.
- iss_ready = !pending[iss_rd] || iss_rd==0.
- Set pending[iss_rd] on iss_valid && iss_ready && iss_rd!=0.
- Clear pending[rf_a3] when the FIFO head is granted.
- Set and clear of the same register in one cycle cannot occur, because iss_ready=0 while the register is pending.
- busyN = pending[qN], combinational. Busy drops the cycle after the head write is granted; the regfile holds the value after the following negedge.

Error flag:
- err_waw sets when WB is granted while pending[wb_rd]=1, and holds until reset. The write still proceeds.

Test Plan:
1. Reset: hold reset_n=0 two cycles with wb_we=1 -> rf_we=0, md_ready=0, iss_ready=0; release -> md_ready=1, all busy=0.
2. Issue iss_rd=5, then md result rd=5 data 0xDEADBEEF with WB idle -> busy for q=5 asserts the cycle after issue; rf_we=1, rf_a3=5, rf_wd3=0xDEADBEEF the cycle after enqueue; busy clears the next cycle.
3. Collision: FIFO holds rd=7; WB writes rd=3 every cycle -> WB granted 3 cycles, then on the 4th cycle wb_stall=1 and x7 is written; WB rd=3 is granted the next cycle.
4. Fill: enqueue 4 MD results with WB busy -> md_ready=0 after the 4th. Then one dequeue with a simultaneous md_valid -> that cycle md_ready=0 and the new result is not taken; md_ready=1 the next cycle.
5. x0 handling: wb_we=1 wb_rd=0 -> FIFO head granted. md_rd=0 -> accepted, never written, FIFO count unchanged. iss_rd=0 -> iss_ready=1, no busy.
6. Hazards: issue rd=9 twice back-to-back -> second iss_ready=0. WB write to rd=9 while pending -> err_waw=1 and stays 1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regfile write port between the WB stage and the
// multiply/divide unit. WB wins unless the MD FIFO head has waited
// STARVE_LIMIT cycles. A pending mask tracks destinations still owed by MD.
module rf_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  q1,
  input  logic [4:0]  q2,
  input  logic [4:0]  q3,
  output logic        busy1,
  output logic        busy2,
  output logic        busy3,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic        err_waw
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_fcnt;
  logic [SW-1:0] r_scnt;
  logic [31:0]   r_pend;
  logic          r_err;

  logic          w_empty, w_full, w_wb_req, w_starve;
  logic          w_head_gnt, w_wb_gnt, w_enq, w_iss_set;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [31:0]   w_pend_nxt;

  assign w_empty     = (r_fcnt == '0);
  assign w_full      = (r_fcnt == CW'(DEPTH));
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];
  assign w_wb_req    = wb_we && (wb_rd != 5'd0);
  assign w_starve    = (r_scnt == SW'(STARVE_LIMIT)) && !w_empty;

  // Head wins when starved or when WB is idle; reset kills every grant.
  assign w_head_gnt  = reset_n && !w_empty && (w_starve || !w_wb_req);
  assign w_wb_gnt    = reset_n && w_wb_req && !w_starve;
  assign wb_stall    = reset_n && w_starve && w_wb_req;

  // md_ready looks only at the current level, never at a same-cycle dequeue.
  assign md_ready    = reset_n && !w_full;
  assign w_enq       = md_valid && md_ready && (md_rd != 5'd0);

  assign iss_ready   = reset_n && (!r_pend[iss_rd] || (iss_rd == 5'd0));
  assign w_iss_set   = iss_valid && iss_ready && (iss_rd != 5'd0);

  assign busy1       = r_pend[q1];
  assign busy2       = r_pend[q2];
  assign busy3       = r_pend[q3];
  assign err_waw     = r_err;

  // Write-port mux; address/data are zeroed when nothing is granted.
  always_comb begin
    rf_we  = 1'b0;
    rf_a3  = 5'd0;
    rf_wd3 = 32'd0;
    if (w_head_gnt) begin
      rf_we  = 1'b1;
      rf_a3  = w_head_rd;
      rf_wd3 = w_head_data;
    end else if (w_wb_gnt) begin
      rf_we  = 1'b1;
      rf_a3  = wb_rd;
      rf_wd3 = wb_data;
    end
  end

  // Next pending mask: head write clears, issue sets; x0 is never pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_head_gnt) w_pend_nxt[w_head_rd] = 1'b0;
    if (w_iss_set)  w_pend_nxt[iss_rd]    = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  // FIFO storage; contents need no reset since pointers/count gate them.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_rd[r_wptr]   <= md_rd;
      r_fifo_data[r_wptr] <= md_data;
    end
  end

  // Pointers, count, starve counter, pending mask and sticky error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
      r_scnt <= '0;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_enq)      r_wptr <= r_wptr + 1'b1;
      if (w_head_gnt) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_head_gnt})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
      if (w_empty || w_head_gnt)
        r_scnt <= '0;
      else if (r_scnt != SW'(STARVE_LIMIT))
        r_scnt <= r_scnt + 1'b1;
      r_pend <= w_pend_nxt;
      if (w_wb_gnt && r_pend[wb_rd]) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with constant expectations,
// then a randomized run against a queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk, reset_n;
  logic        wb_we, wb_stall, md_valid, md_ready, iss_valid, iss_ready;
  logic [4:0]  wb_rd, md_rd, iss_rd, q1, q2, q3, rf_a3;
  logic [31:0] wb_data, md_data, rf_wd3;
  logic        busy1, busy2, busy3, rf_we, err_waw;

  int errs = 0;
  int checks = 0;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .q1(q1), .q2(q2), .q3(q3), .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .err_waw(err_waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 0; wb_rd = 0; wb_data = 0; md_valid = 0; md_rd = 0; md_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); q1 = 5; q2 = 7; q3 = 9;
    wb_we = 1; wb_rd = 3; wb_data = 32'h1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({rf_we, md_ready, iss_ready, wb_stall} !== 4'b0000) begin
        errs++;
        $display("FAIL reset_forced act=%b exp=0000", {rf_we, md_ready, iss_ready, wb_stall});
      end
      tick();
    end
    reset_n = 1; idle();
    @(negedge clk);
    checks++;
    if ({md_ready, iss_ready, busy1, busy2, busy3, rf_we, err_waw} !== 7'b1100000) begin
      errs++;
      $display("FAIL reset_release act=%b exp=1100000",
               {md_ready, iss_ready, busy1, busy2, busy3, rf_we, err_waw});
    end
  endtask

  task automatic test_issue_writeback();
    tick(); iss_valid = 1; iss_rd = 5; q1 = 5;
    @(negedge clk);
    checks++;
    if ({iss_ready, busy1} !== 2'b10) begin
      errs++; $display("FAIL issue_accept act=%b exp=10", {iss_ready, busy1});
    end
    tick(); iss_valid = 0; md_valid = 1; md_rd = 5; md_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({busy1, rf_we, md_ready} !== 3'b101) begin
      errs++; $display("FAIL issue_busy act=%b exp=101", {busy1, rf_we, md_ready});
    end
    tick(); md_valid = 0;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_a3, rf_wd3, busy1} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
      errs++; $display("FAIL md_write act=%h exp=%h", {rf_we, rf_a3, rf_wd3, busy1},
                       {1'b1, 5'd5, 32'hDEADBEEF, 1'b1});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rf_we, busy1} !== 2'b00) begin
      errs++; $display("FAIL busy_clear act=%b exp=00", {rf_we, busy1});
    end
  endtask

  task automatic test_collision();
    tick(); md_valid = 1; md_rd = 7; md_data = 32'h77;
    wb_we = 1; wb_rd = 3; wb_data = 32'h33;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_a3, wb_stall} !== {1'b1, 5'd3, 1'b0}) begin
      errs++; $display("FAIL coll_enq act=%h exp=%h", {rf_we, rf_a3, wb_stall}, {1'b1, 5'd3, 1'b0});
    end
    tick(); md_valid = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      checks++;
      if ({rf_we, rf_a3, rf_wd3, wb_stall} !== {1'b1, 5'd3, 32'h33, 1'b0}) begin
        errs++; $display("FAIL coll_wb%0d act=%h exp=%h", i, {rf_we, rf_a3, rf_wd3, wb_stall},
                         {1'b1, 5'd3, 32'h33, 1'b0});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({rf_we, rf_a3, rf_wd3, wb_stall} !== {1'b1, 5'd7, 32'h77, 1'b1}) begin
      errs++; $display("FAIL coll_starve act=%h exp=%h", {rf_we, rf_a3, rf_wd3, wb_stall},
                       {1'b1, 5'd7, 32'h77, 1'b1});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rf_we, rf_a3, wb_stall} !== {1'b1, 5'd3, 1'b0}) begin
      errs++; $display("FAIL coll_resume act=%h exp=%h", {rf_we, rf_a3, wb_stall}, {1'b1, 5'd3, 1'b0});
    end
    tick(); idle();
  endtask

  task automatic test_fill();
    wb_we = 1; wb_rd = 3; wb_data = 32'h33;
    for (int i = 0; i < DEPTH; i++) begin
      md_valid = 1; md_rd = 5'(10 + i); md_data = 32'(i);
      @(negedge clk);
      checks++;
      if (md_ready !== 1'b1) begin
        errs++; $display("FAIL fill_ready%0d act=%b exp=1", i, md_ready);
      end
      tick();
    end
    md_valid = 1; md_rd = 14; md_data = 32'hEE;
    @(negedge clk);
    checks++;
    if ({md_ready, wb_stall, rf_a3} !== {1'b0, 1'b1, 5'd10}) begin
      errs++; $display("FAIL fill_full act=%h exp=%h", {md_ready, wb_stall, rf_a3}, {1'b0, 1'b1, 5'd10});
    end
    tick(); md_valid = 0;
    @(negedge clk);
    checks++;
    if ({md_ready, rf_a3} !== {1'b1, 5'd3}) begin
      errs++; $display("FAIL fill_reopen act=%h exp=%h", {md_ready, rf_a3}, {1'b1, 5'd3});
    end
    tick(); wb_we = 0;
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'(10 + i), 32'(i)}) begin
        errs++; $display("FAIL fill_drain%0d act=%h exp=%h", i, {rf_we, rf_a3, rf_wd3},
                         {1'b1, 5'(10 + i), 32'(i)});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      errs++; $display("FAIL fill_refused act=%b exp=0", rf_we);
    end
  endtask

  task automatic test_x0();
    tick(); md_valid = 1; md_rd = 20; md_data = 32'h2020;
    tick(); md_valid = 0; wb_we = 1; wb_rd = 0; wb_data = 32'h55;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_a3, rf_wd3, wb_stall} !== {1'b1, 5'd20, 32'h2020, 1'b0}) begin
      errs++; $display("FAIL x0_wb act=%h exp=%h", {rf_we, rf_a3, rf_wd3, wb_stall},
                       {1'b1, 5'd20, 32'h2020, 1'b0});
    end
    tick(); wb_we = 0; md_valid = 1; md_rd = 0; md_data = 32'h99;
    iss_valid = 1; iss_rd = 0; q1 = 0;
    @(negedge clk);
    checks++;
    if ({md_ready, iss_ready} !== 2'b11) begin
      errs++; $display("FAIL x0_accept act=%b exp=11", {md_ready, iss_ready});
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if ({rf_we, busy1} !== 2'b00) begin
      errs++; $display("FAIL x0_discard act=%b exp=00", {rf_we, busy1});
    end
  endtask

  task automatic test_hazard();
    tick(); iss_valid = 1; iss_rd = 9; q1 = 9;
    @(negedge clk);
    checks++;
    if (iss_ready !== 1'b1) begin
      errs++; $display("FAIL haz_first act=%b exp=1", iss_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({iss_ready, busy1} !== 2'b01) begin
      errs++; $display("FAIL haz_second act=%b exp=01", {iss_ready, busy1});
    end
    tick(); iss_valid = 0; wb_we = 1; wb_rd = 9; wb_data = 32'h9;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_a3, err_waw} !== {1'b1, 5'd9, 1'b0}) begin
      errs++; $display("FAIL haz_wb act=%h exp=%h", {rf_we, rf_a3, err_waw}, {1'b1, 5'd9, 1'b0});
    end
    tick(); wb_we = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({err_waw, busy1} !== 2'b11) begin
        errs++; $display("FAIL haz_sticky%0d act=%b exp=11", i, {err_waw, busy1});
      end
      tick();
    end
  endtask

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  task automatic test_random();
    ent_t        mq[$];
    ent_t        hd;
    logic [31:0] m_pend;
    int          m_cnt;
    logic        m_err, wbreq, starve, hg, wbg, mr, ir, empty;
    logic [44:0] exp_v, act_v;
    logic [4:0]  ea3;
    logic [31:0] ewd;
    reset_n = 0; idle();
    tick(); tick();
    reset_n = 1;
    m_pend = 0; m_cnt = 0; m_err = 0;
    for (int n = 0; n < 500; n++) begin
      wb_we     = ($urandom_range(0, 99) < 55);
      wb_rd     = 5'($urandom_range(0, 15));
      wb_data   = $urandom;
      md_valid  = ($urandom_range(0, 99) < 45);
      md_rd     = 5'($urandom_range(0, 15));
      md_data   = $urandom;
      iss_valid = ($urandom_range(0, 99) < 40);
      iss_rd    = 5'($urandom_range(0, 15));
      q1 = 5'($urandom_range(0, 15));
      q2 = 5'($urandom_range(0, 15));
      q3 = 5'($urandom_range(0, 15));
      @(negedge clk);
      empty  = (mq.size() == 0);
      wbreq  = wb_we && (wb_rd != 0);
      starve = (m_cnt == LIMIT) && !empty;
      hg     = !empty && (starve || !wbreq);
      wbg    = wbreq && !starve;
      mr     = (mq.size() < DEPTH);
      ir     = !m_pend[iss_rd] || (iss_rd == 0);
      ea3 = 0; ewd = 0;
      if (hg) begin ea3 = mq[0].rd; ewd = mq[0].data; end
      else if (wbg) begin ea3 = wb_rd; ewd = wb_data; end
      exp_v = {hg || wbg, ea3, ewd, starve && wbreq, mr, ir,
               m_pend[q1], m_pend[q2], m_pend[q3], m_err};
      act_v = {rf_we, rf_a3, rf_wd3, wb_stall, md_ready, iss_ready,
               busy1, busy2, busy3, err_waw};
      checks++;
      if (act_v !== exp_v) begin
        errs++; $display("FAIL rand_cyc%0d act=%h exp=%h", n, act_v, exp_v);
      end
      if (wbg && m_pend[wb_rd]) m_err = 1;
      if (hg) begin hd = mq.pop_front(); m_pend[hd.rd] = 0; end
      if (iss_valid && ir && iss_rd != 0) m_pend[iss_rd] = 1;
      if (md_valid && mr && md_rd != 0) mq.push_back('{rd: md_rd, data: md_data});
      if (!empty && !hg) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
      else m_cnt = 0;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_issue_writeback();
    test_collision();
    test_fill();
    test_x0();
    test_hazard();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
